// File: rtl/dpc_io_pkg.sv
// Shared types and defaults for the DekatronPC I/O blocks.
package dpc_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2
    } print_state_t;

    // About 0.1 s at the 1 MHz emulator clock: well beyond any real character time.
    localparam int PRINT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-pointer register-array queue; level is the only full/empty indication.
// Zero-latency head read; caller gates push/pop against full/empty, flush wins over both.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Pointers wrap on their own; only the count needs the push/pop pairing.
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tx_print_queue.sv
// Character queue between the CPU print path and a slow printer sink, with hang watchdog.
// Head presented one cycle after it is visible in the queue; character retired on sink prn_rdy rise.
module tx_print_queue
    import dpc_io_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH_LOG2     = 4,
    parameter int TIMEOUT_CYCLES = PRINT_TIMEOUT_CYCLES
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    output logic [DATA_WIDTH-1:0] prn_data,
    output logic                  prn_vld,
    input  logic                  prn_rdy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  WD_LAST  = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    print_state_t          state;
    logic                  prn_rdy_q;
    logic [CNT_W-1:0]      wdog;
    logic [DATA_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;
    logic                  done;
    logic                  wd_expire;

    // Decoded from the registered count only, so the sink never reaches wr_rdy combinationally.
    assign wr_rdy    = (level != FULL_LVL);
    assign push      = wr_vld && wr_rdy && !flush;
    assign done      = (state == BUSY) && !prn_rdy_q && prn_rdy;
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (wdog == WD_LAST);
    assign pop       = !flush && (done || wd_expire);

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_data),
        .rdata (head),
        .level (level)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            prn_vld   <= 1'b0;
            prn_data  <= '0;
            prn_rdy_q <= 1'b0;
            wdog      <= '0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            prn_rdy_q <= prn_rdy;
            if (flush) begin
                state    <= IDLE;
                prn_vld  <= 1'b0;
                wdog     <= '0;
                overflow <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                if (wr_vld && !wr_rdy) begin
                    overflow <= 1'b1;
                end
                // A genuine completion on the expiry cycle is not a drop.
                if (wd_expire && !done) begin
                    timeout <= 1'b1;
                end
                if ((TIMEOUT_CYCLES != 0) && (state != IDLE)) begin
                    wdog <= wdog + 1'b1;
                end
                case (state)
                    IDLE: begin
                        if ((level != '0) && prn_rdy) begin
                            state    <= SEND;
                            prn_vld  <= 1'b1;
                            prn_data <= head;
                            wdog     <= '0;
                        end
                    end
                    SEND: begin
                        if (wd_expire || !prn_rdy) begin
                            state   <= wd_expire ? IDLE : BUSY;
                            prn_vld <= 1'b0;
                        end
                    end
                    BUSY: begin
                        if (pop) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        prn_vld <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_print_queue.sv
// Scoreboard bench for tx_print_queue: main instance plus short-timeout and no-timeout instances.
module tb_tx_print_queue;
    import dpc_io_pkg::*;

    logic       Clk;
    logic       Rst_n;
    logic       flush;
    logic [7:0] wr_data;
    logic       wr_vld;
    logic       wr_rdy;
    logic [7:0] prn_data;
    logic       prn_vld;
    logic       prn_rdy;
    logic [4:0] level;
    logic       overflow;
    logic       timeout;

    logic       t_flush;
    logic [7:0] t_wr_data;
    logic       t_wr_vld;
    logic       t_prn_rdy;
    logic       wr_rdy_t, prn_vld_t, overflow_t, timeout_t;
    logic [7:0] prn_data_t;
    logic [4:0] level_t;
    logic       wr_rdy_z, prn_vld_z, overflow_z, timeout_z;
    logic [7:0] prn_data_z;
    logic [4:0] level_z;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] sb[$];
    logic [7:0] sb_t[$];

    tx_print_queue dut (
        .Clk(Clk), .Rst_n(Rst_n), .flush(flush), .wr_data(wr_data), .wr_vld(wr_vld),
        .wr_rdy(wr_rdy), .prn_data(prn_data), .prn_vld(prn_vld), .prn_rdy(prn_rdy),
        .level(level), .overflow(overflow), .timeout(timeout)
    );

    tx_print_queue #(.TIMEOUT_CYCLES(20)) dut_t (
        .Clk(Clk), .Rst_n(Rst_n), .flush(t_flush), .wr_data(t_wr_data), .wr_vld(t_wr_vld),
        .wr_rdy(wr_rdy_t), .prn_data(prn_data_t), .prn_vld(prn_vld_t), .prn_rdy(t_prn_rdy),
        .level(level_t), .overflow(overflow_t), .timeout(timeout_t)
    );

    tx_print_queue #(.TIMEOUT_CYCLES(0)) dut_z (
        .Clk(Clk), .Rst_n(Rst_n), .flush(t_flush), .wr_data(t_wr_data), .wr_vld(t_wr_vld),
        .wr_rdy(wr_rdy_z), .prn_data(prn_data_z), .prn_vld(prn_vld_z), .prn_rdy(t_prn_rdy),
        .level(level_z), .overflow(overflow_z), .timeout(timeout_z)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_char(input logic [7:0] d);
        wr_data = d;
        wr_vld  = 1'b1;
        tick();
        wr_vld  = 1'b0;
        sb.push_back(d);
    endtask

    task automatic flush_q();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
    endtask

    // Wait for a presented character, score it, then take it like a sink does.
    task automatic to_busy();
        logic [7:0] exp;
        for (int i = 0; i < 64 && prn_vld !== 1'b1; i++) tick();
        tests_run++;
        if (prn_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL present_wait: prn_vld=%b never rose, required 1", prn_vld);
        end else if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL present_extra: prn_data=%h presented, no character expected", prn_data);
        end else begin
            exp = sb.pop_front();
            if (prn_data !== exp) begin
                tests_failed++;
                $display("FAIL present_order: prn_data=%h required %h", prn_data, exp);
            end
        end
        prn_rdy = 1'b0;
        tick();
    endtask

    task automatic serve_one(input int hold);
        to_busy();
        repeat (hold - 1) tick();
        prn_rdy = 1'b1;
    endtask

    task automatic test_reset();
        tests_run++;
        if (prn_vld !== 1'b0 || prn_data !== 8'h00 || wr_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_out: vld=%b data=%h wr_rdy=%b required 0 00 1", prn_vld, prn_data, wr_rdy);
        end
        tests_run++;
        if (level !== 5'd0 || overflow !== 1'b0 || timeout !== 1'b0 || dut.state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: level=%0d ovf=%b to=%b state=%0d required 0 0 0 0",
                     level, overflow, timeout, dut.state);
        end
    endtask

    task automatic test_single();
        push_char(8'h41);
        tests_run++;
        if (level !== 5'd1 || prn_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_push: level=%0d vld=%b required 1 0", level, prn_vld);
        end
        tick();
        tests_run++;
        if (prn_vld !== 1'b1 || prn_data !== 8'h41) begin
            tests_failed++;
            $display("FAIL single_present: vld=%b data=%h required 1 41", prn_vld, prn_data);
        end
        void'(sb.pop_front());
        prn_rdy = 1'b0;
        tick();
        tests_run++;
        if (prn_vld !== 1'b0 || dut.state !== BUSY) begin
            tests_failed++;
            $display("FAIL single_busy: vld=%b state=%0d required 0 2", prn_vld, dut.state);
        end
        repeat (4) tick();
        prn_rdy = 1'b1;
        tick();
        tests_run++;
        if (level !== 5'd0 || dut.state !== IDLE || overflow !== 1'b0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: level=%0d state=%0d ovf=%b to=%b required 0 0 0 0",
                     level, dut.state, overflow, timeout);
        end
    endtask

    task automatic test_fill_wrap();
        prn_rdy = 1'b0;
        for (int i = 0; i < 16; i++) push_char(8'h30 + 8'(i));
        tests_run++;
        if (wr_rdy !== 1'b0 || level !== 5'd16) begin
            tests_failed++;
            $display("FAIL fill_full: wr_rdy=%b level=%0d required 0 16", wr_rdy, level);
        end
        wr_data = 8'h40;
        wr_vld  = 1'b1;
        tick();
        wr_vld  = 1'b0;
        tests_run++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            tests_failed++;
            $display("FAIL fill_overflow: ovf=%b level=%0d required 1 16", overflow, level);
        end
        prn_rdy = 1'b1;
        for (int i = 0; i < 16; i++) serve_one(2);
        tick();
        tick();
        tests_run++;
        if (level !== 5'd0 || prn_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_drain: level=%0d vld=%b required 0 0", level, prn_vld);
        end
    endtask

    task automatic test_pushpop_level5();
        flush_q();
        prn_rdy = 1'b1;
        for (int i = 0; i < 5; i++) push_char(8'h70 + 8'(i));
        to_busy();
        wr_data = 8'h75;
        wr_vld  = 1'b1;
        prn_rdy = 1'b1;
        tick();
        wr_vld  = 1'b0;
        sb.push_back(8'h75);
        tests_run++;
        if (level !== 5'd5 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL pushpop_level: level=%0d ovf=%b required 5 0", level, overflow);
        end
        for (int i = 0; i < 5; i++) serve_one(1);
        tick();
        tick();
        tests_run++;
        if (level !== 5'd0) begin
            tests_failed++;
            $display("FAIL pushpop_drain: level=%0d required 0", level);
        end
    endtask

    task automatic test_full_collide();
        flush_q();
        prn_rdy = 1'b1;
        for (int i = 0; i < 16; i++) push_char(8'h80 + 8'(i));
        to_busy();
        wr_data = 8'hEE;
        wr_vld  = 1'b1;
        prn_rdy = 1'b1;
        tick();
        wr_vld  = 1'b0;
        tests_run++;
        if (level !== 5'd15 || overflow !== 1'b1 || wr_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL collide_full: level=%0d ovf=%b wr_rdy=%b required 15 1 1", level, overflow, wr_rdy);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) serve_one(1);
        to_busy();
        tests_run++;
        if (level !== 5'd7 || overflow !== 1'b1 || dut.state !== BUSY) begin
            tests_failed++;
            $display("FAIL flush_pre: level=%0d ovf=%b state=%0d required 7 1 2", level, overflow, dut.state);
        end
        flush   = 1'b1;
        wr_data = 8'h7E;
        wr_vld  = 1'b1;
        tick();
        flush   = 1'b0;
        wr_vld  = 1'b0;
        sb.delete();
        tests_run++;
        if (level !== 5'd0 || prn_vld !== 1'b0 || wr_rdy !== 1'b1 || overflow !== 1'b0 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_clear: level=%0d vld=%b wr_rdy=%b ovf=%b to=%b required 0 0 1 0 0",
                     level, prn_vld, wr_rdy, overflow, timeout);
        end
        prn_rdy = 1'b1;
        tick();
        tick();
        tests_run++;
        if (level !== 5'd0 || prn_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_pop: level=%0d vld=%b required 0 0", level, prn_vld);
        end
        push_char(8'h61);
        serve_one(1);
        tick();
        tests_run++;
        if (level !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_after: level=%0d required 0", level);
        end
    endtask

    task automatic test_watchdog();
        int cnt;
        t_prn_rdy = 1'b1;
        t_wr_data = 8'h51;
        t_wr_vld  = 1'b1;
        sb_t.push_back(8'h51);
        tick();
        t_wr_data = 8'h52;
        sb_t.push_back(8'h52);
        tick();
        t_wr_vld  = 1'b0;
        for (int i = 0; i < 64 && prn_vld_t !== 1'b1; i++) tick();
        tests_run++;
        if (prn_vld_t !== 1'b1 || prn_data_t !== sb_t[0]) begin
            tests_failed++;
            $display("FAIL wd_first: vld=%b data=%h required 1 %h", prn_vld_t, prn_data_t, sb_t[0]);
        end
        void'(sb_t.pop_front());
        cnt = 0;
        while (prn_vld_t === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        tests_run++;
        if (cnt != 20 || timeout_t !== 1'b1 || level_t !== 5'd1) begin
            tests_failed++;
            $display("FAIL wd_drop: send_cycles=%0d to=%b level=%0d required 20 1 1", cnt, timeout_t, level_t);
        end
        for (int i = 0; i < 64 && prn_vld_t !== 1'b1; i++) tick();
        tests_run++;
        if (prn_vld_t !== 1'b1 || prn_data_t !== sb_t[0]) begin
            tests_failed++;
            $display("FAIL wd_next: vld=%b data=%h required 1 %h", prn_vld_t, prn_data_t, sb_t[0]);
        end
        tests_run++;
        if (prn_vld_z !== 1'b1 || prn_data_z !== 8'h51 || timeout_z !== 1'b0 || level_z !== 5'd2) begin
            tests_failed++;
            $display("FAIL wd_disabled: vld=%b data=%h to=%b level=%0d required 1 51 0 2",
                     prn_vld_z, prn_data_z, timeout_z, level_z);
        end
    endtask

    task automatic test_async_reset();
        prn_rdy = 1'b1;
        push_char(8'h33);
        for (int i = 0; i < 64 && prn_vld !== 1'b1; i++) tick();
        #3;
        Rst_n = 1'b0;
        #1;
        tests_run++;
        if (prn_vld !== 1'b0 || level !== 5'd0 || wr_rdy !== 1'b1 || dut.state !== IDLE) begin
            tests_failed++;
            $display("FAIL areset: vld=%b level=%0d wr_rdy=%b state=%0d required 0 0 1 0",
                     prn_vld, level, wr_rdy, dut.state);
        end
        sb.delete();
        #2;
        Rst_n = 1'b1;
        tick();
        push_char(8'h5A);
        serve_one(1);
        tick();
        tests_run++;
        if (level !== 5'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_resume: level=%0d ovf=%b required 0 0", level, overflow);
        end
    endtask

    initial begin
        Rst_n     = 1'b0;
        flush     = 1'b0;
        wr_data   = 8'h00;
        wr_vld    = 1'b0;
        prn_rdy   = 1'b1;
        t_flush   = 1'b0;
        t_wr_data = 8'h00;
        t_wr_vld  = 1'b0;
        t_prn_rdy = 1'b1;
        #23;
        Rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_fill_wrap();
        test_pushpop_level5();
        test_full_collide();
        test_flush();
        test_watchdog();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
